// File: rtl/unsigned_calc_pkg.sv
// Shared constants, cursor payload and FSM state type for the 7A-3B+6C inverse solver.
// Also used by the UNSIGNED_CALC_SOLVER_ITER_EN build (iteration-count width W_ITER).
package unsigned_calc_pkg;

    localparam int unsigned W_IN   = 4;
    localparam int unsigned W_OUT  = 9;
    localparam int unsigned W_ACC  = 10;
    localparam int unsigned W_IDX  = 3 * W_IN;
    localparam int unsigned W_ITER = W_IDX + 1;

    localparam int KA     = 7;
    localparam int KB     = 3;
    localparam int KC     = 6;
    localparam int OP_MAX = 15;

    // V change for each carry pattern of the C-fastest scan order
    localparam int DELTA_C = KC;
    localparam int DELTA_B = -(KC * OP_MAX) - KB;
    localparam int DELTA_A = -(KC * OP_MAX) + (KB * OP_MAX) + KA;

    localparam logic [W_IN-1:0]   OP_MAX_U     = W_IN'(OP_MAX);
    localparam logic [W_ITER-1:0] ITER_NOTFOUND = W_ITER'(1 << W_IDX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Current search point: operands plus running value V = 7a - 3b + 6c
    typedef struct packed {
        logic [W_IN-1:0]         a;
        logic [W_IN-1:0]         b;
        logic [W_IN-1:0]         c;
        logic signed [W_ACC-1:0] v;
    } cursor_t;

    function automatic logic signed [W_ACC-1:0] sext_target(input logic signed [W_OUT-1:0] t);
        return W_ACC'(t);
    endfunction

endpackage

// File: rtl/unsigned_calc_step_v.sv
// Combinational successor of a search cursor; V advances by constant deltas only.
module unsigned_calc_step_v
    import unsigned_calc_pkg::*;
(
    input  cursor_t cur_i,
    output cursor_t nxt_c_o,
    output logic    last_c_o
);

    localparam logic signed [W_ACC-1:0] D_C = W_ACC'(DELTA_C);
    localparam logic signed [W_ACC-1:0] D_B = W_ACC'(DELTA_B);
    localparam logic signed [W_ACC-1:0] D_A = W_ACC'(DELTA_A);

    logic c_max;
    logic b_max;
    logic a_max;

    assign c_max = (cur_i.c == OP_MAX_U);
    assign b_max = (cur_i.b == OP_MAX_U);
    assign a_max = (cur_i.a == OP_MAX_U);

    always_comb begin
        nxt_c_o  = cur_i;
        last_c_o = a_max && b_max && c_max;
        if (!c_max) begin
            nxt_c_o.c = cur_i.c + W_IN'(1);
            nxt_c_o.v = cur_i.v + D_C;
        end else if (!b_max) begin
            nxt_c_o.c = '0;
            nxt_c_o.b = cur_i.b + W_IN'(1);
            nxt_c_o.v = cur_i.v + D_B;
        end else begin
            nxt_c_o.c = '0;
            nxt_c_o.b = '0;
            nxt_c_o.a = cur_i.a + W_IN'(1);
            nxt_c_o.v = cur_i.v + D_A;
        end
    end

endmodule

// File: rtl/unsigned_calc_solver_v.sv
// Sequential search for the first (A,B,C) with 7A-3B+6C == target, C fastest.
// Optional UNSIGNED_CALC_SOLVER_ITER_EN adds o_iter (indices tested per search).
module unsigned_calc_solver_v
    import unsigned_calc_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic signed [W_OUT-1:0] i_target,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_found,
    output logic [W_IN-1:0]         o_au,
    output logic [W_IN-1:0]         o_bu,
    output logic [W_IN-1:0]         o_cu
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
    ,
    output logic [W_ITER-1:0]       o_iter
`endif
);

    state_e                  state_q, state_d;
    cursor_t                 cur_q, cur_d;
    logic signed [W_ACC-1:0] target_q, target_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    found_q, found_d;
    logic [W_IN-1:0]         au_q, au_d;
    logic [W_IN-1:0]         bu_q, bu_d;
    logic [W_IN-1:0]         cu_q, cu_d;
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
    logic [W_ITER-1:0]       iter_q, iter_d;
    logic [W_IDX-1:0]        idx;
`endif

    cursor_t step_nxt;
    logic    step_last;
    logic    hit;

    unsigned_calc_step_v u_step (
        .cur_i    (cur_q),
        .nxt_c_o  (step_nxt),
        .last_c_o (step_last)
    );

    assign hit = (cur_q.v == target_q);
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
    assign idx = {cur_q.a, cur_q.b, cur_q.c};
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            au_q     <= '0;
            bu_q     <= '0;
            cu_q     <= '0;
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
            iter_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            target_q <= target_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            au_q     <= au_d;
            bu_q     <= bu_d;
            cu_q     <= cu_d;
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
            iter_q   <= iter_d;
`endif
        end
    end

    // Next state plus result latching; results stay held between searches
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        target_d = target_q;
        done_d   = 1'b0;
        found_d  = found_q;
        au_d     = au_q;
        bu_d     = bu_q;
        cu_d     = cu_q;
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
        iter_d   = iter_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = SEARCH;
                    cur_d    = '0;
                    target_d = sext_target(i_target);
                end
            end
            SEARCH: begin
                if (hit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    found_d = 1'b1;
                    au_d    = cur_q.a;
                    bu_d    = cur_q.b;
                    cu_d    = cur_q.c;
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
                    iter_d  = W_ITER'(idx) + W_ITER'(1);
`endif
                end else if (step_last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    found_d = 1'b0;
                    au_d    = '0;
                    bu_d    = '0;
                    cu_d    = '0;
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
                    iter_d  = ITER_NOTFOUND;
`endif
                end else begin
                    cur_d = step_nxt;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SEARCH);
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_found = found_q;
    assign o_au    = au_q;
    assign o_bu    = bu_q;
    assign o_cu    = cu_q;
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
    assign o_iter  = iter_q;
`endif

endmodule

// File: tb/tb_unsigned_calc_solver_v.sv
// Directed + random bench for unsigned_calc_solver_v against a brute-force reference search.
module tb_unsigned_calc_solver_v;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [8:0] i_target;
    logic       o_busy;
    logic       o_done;
    logic       o_found;
    logic [3:0] o_au;
    logic [3:0] o_bu;
    logic [3:0] o_cu;
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
    logic [12:0] o_iter;
`endif

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    unsigned_calc_solver_v dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_target (i_target),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_found  (o_found),
        .o_au     (o_au),
        .o_bu     (o_bu),
        .o_cu     (o_cu)
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
        ,
        .o_iter   (o_iter)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Brute-force scan in the required order: A slowest, then B, then C fastest
    function automatic void ref_solve(input int f, output bit found,
                                      output int a, output int b, output int c, output int n);
        found = 1'b0; a = 0; b = 0; c = 0; n = 4095;
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 16; ic++)
                    if (!found && (7 * ia - 3 * ib + 6 * ic == f)) begin
                        found = 1'b1; a = ia; b = ib; c = ic; n = ia * 256 + ib * 16 + ic;
                    end
    endfunction

    task automatic run_search(input string tag, input int t, input bit disturb);
        bit ef;
        int ea, eb, ec, en;
        int lat;
        bit seen, busy_ok;
        ref_solve(t, ef, ea, eb, ec, en);
        @(negedge i_clk);
        i_target = 9'(t);
        i_start  = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        chk({tag, " busy_after_accept"}, 32'(o_busy), 32'd1);
        seen = 1'b0; busy_ok = 1'b1; lat = 0;
        for (int m = 1; m <= 4200; m++) begin
            @(posedge i_clk);
            #1;
            if (disturb) begin
                if (m == 3)  begin i_start = 1'b1; i_target = 9'($urandom); end
                if (m == 8)  i_start = 1'b0;
                if (m == 20) i_target = 9'($urandom);
            end
            if (o_done === 1'b1) begin
                seen = 1'b1;
                lat  = m;
                break;
            end
            if (o_busy !== 1'b1) busy_ok = 1'b0;
        end
        i_start = 1'b0;
        chk({tag, " done_seen"},   32'(seen), 32'd1);
        chk({tag, " latency"},     32'(lat), 32'(en + 1));
        chk({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, " busy_at_done"}, 32'(o_busy), 32'd0);
        chk({tag, " found"},       32'(o_found), 32'(ef));
        chk({tag, " a"},           32'(o_au), 32'(ea));
        chk({tag, " b"},           32'(o_bu), 32'(eb));
        chk({tag, " c"},           32'(o_cu), 32'(ec));
`ifdef UNSIGNED_CALC_SOLVER_ITER_EN
        chk({tag, " iter"},        32'(o_iter), ef ? 32'(en + 1) : 32'd4096);
`endif
        @(posedge i_clk);
        #1;
        chk({tag, " done_one_cycle"}, 32'(o_done), 32'd0);
        chk({tag, " found_held"},     32'(o_found), 32'(ef));
        chk({tag, " a_held"},         32'(o_au), 32'(ea));
    endtask

    initial begin
        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_target = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst busy",  32'(o_busy), 32'd0);
        chk("rst done",  32'(o_done), 32'd0);
        chk("rst found", 32'(o_found), 32'd0);
        chk("rst abc",   32'({o_au, o_bu, o_cu}), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        run_search("t0",    0,   1'b0);
        run_search("t7",    7,   1'b0);
        run_search("tm45",  -45, 1'b0);
        run_search("t195",  195, 1'b0);
        run_search("t194",  194, 1'b0);
        run_search("tm46",  -46, 1'b0);
        run_search("dist7", 7,   1'b1);

        // Abort mid-search with reset; prior result (found=1) must clear at once
        @(negedge i_clk);
        i_target = 9'(194);
        i_start  = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (99) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        chk("abort busy",  32'(o_busy), 32'd0);
        chk("abort done",  32'(o_done), 32'd0);
        chk("abort found", 32'(o_found), 32'd0);
        chk("abort abc",   32'({o_au, o_bu, o_cu}), 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("abort quiet", 32'({o_busy, o_done}), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        run_search("post_rst", -45, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int t;
            t = int'($urandom_range(0, 250)) - 50;
            run_search($sformatf("rnd%0d_t%0d", r, t), t, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
